// File: rtl/sram_pkt_reader_pkg.sv
// Shared types and widths for the packet read engine.
// Word tags travel with the data so the output side needs no separate bookkeeping.
package sram_pkt_reader_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 17;
    localparam int LEN_WIDTH  = 8;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } rd_word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sram_pkt_reader_if.sv
// Bundle of descriptor, SRAM B-port and packet output signals for one reader.
// Output beat handshake: a word moves on any cycle with rd_vld & ready; while rd_vld is high and
// ready is low, rd_vld/rd_data/rd_sop/rd_eop stay unchanged; rd_sop/rd_eop mean nothing without rd_vld.
interface sram_pkt_reader_if;
    import sram_pkt_reader_pkg::*;

    logic                            prepared;
    logic [ADDR_WIDTH-1:0]           desc_addr;
    logic [LEN_WIDTH-1:0]            desc_len;
    logic                            rea;
    logic                            rd_request;
    logic                            grant;
    logic [ADDR_WIDTH-1:0]           sram_addr;
    logic [DATA_WIDTH-1:0]           sram_dout;
    logic                            ready;
    logic                            rd_sop;
    logic                            rd_eop;
    logic                            rd_vld;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic                            busy;

    modport master (
        input  prepared, desc_addr, desc_len, grant, sram_dout, ready,
        output rea, rd_request, sram_addr, rd_sop, rd_eop, rd_vld, rd_data, busy
    );

    modport slave (
        output prepared, desc_addr, desc_len, grant, sram_dout, ready,
        input  rea, rd_request, sram_addr, rd_sop, rd_eop, rd_vld, rd_data, busy
    );

endinterface

// File: rtl/sram_pkt_reader_skid_fifo.sv
// Two-entry skid FIFO holding tagged words between the SRAM return path and the output port.
// The caller's credit logic guarantees no push ever lands on a full FIFO without a pop.
module rd_skid_fifo
    import sram_pkt_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  rd_word_t   i_din,
    input  logic       i_pop,
    output rd_word_t   o_dout,
    output logic       o_vld,
    output logic [1:0] o_count
);

    rd_word_t   r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop = i_pop & (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_vld   = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_pkt_reader.sv
// Per-port packet read engine: takes one descriptor, fetches its words from SRAM port B under
// grant, and streams them out through a 2-entry skid FIFO with sop/eop tags.
module sram_pkt_reader
    import sram_pkt_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sram_pkt_reader_if.master bus,
    output rd_state_t         o_state
);

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_rea;
    logic                  r_busy;
    logic                  r_first;
    logic                  r_pend;
    logic                  r_pend_sop;
    logic                  r_pend_eop;

    rd_word_t              w_head;
    rd_word_t              w_push_word;
    logic                  w_vld;
    logic                  w_pop;
    logic [1:0]            w_count;
    logic                  w_credit_ok;
    logic                  w_req;
    logic                  w_fire;

    // A pop this cycle frees a slot, so back-to-back reads sustain one word per cycle.
    assign w_pop       = w_vld & bus.ready;
    assign w_credit_ok = ({1'b0, w_count} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop});
    assign w_req       = (r_state == S_FETCH) && w_credit_ok;
    assign w_fire      = w_req & bus.grant;
    assign w_push_word = {r_pend_sop, r_pend_eop, bus.sram_dout};

    rd_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_din   (w_push_word),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_vld   (w_vld),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_rea      <= 1'b0;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_sop <= 1'b0;
            r_pend_eop <= 1'b0;
        end else begin
            r_rea  <= 1'b0;
            r_pend <= w_fire;
            if (w_fire) begin
                r_pend_sop <= r_first;
                r_pend_eop <= (r_rem == LEN_WIDTH'(1));
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.prepared) begin
                        r_rea <= 1'b1;
                        // Zero-length descriptors are consumed and dropped.
                        if (bus.desc_len != '0) begin
                            r_addr  <= bus.desc_addr;
                            r_rem   <= bus.desc_len;
                            r_busy  <= 1'b1;
                            r_first <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_fire) begin
                        r_addr  <= r_addr + ADDR_WIDTH'(1);
                        r_rem   <= r_rem - LEN_WIDTH'(1);
                        r_first <= 1'b0;
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head.eop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rea        = r_rea;
    assign bus.busy       = r_busy;
    assign bus.rd_request = w_req;
    assign bus.sram_addr  = r_addr;
    assign bus.rd_vld     = w_vld;
    assign bus.rd_sop     = w_head.sop;
    assign bus.rd_eop     = w_head.eop;
    assign bus.rd_data    = w_head.data;
    assign o_state        = r_state;

endmodule
